// File: rtl/fetch_predict.sv
// Instruction fetch PC register with a direct-mapped branch target buffer.
// Each BTB entry pairs a target with a 2-bit saturating taken/not-taken counter.
module fetch_predict #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_out,
  output logic        predict_jump_out,
  output logic [31:0] next_pc,
  output logic        flush_out
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [31:0]      pc_q, pc_d;
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lookupIdx;
  logic [TAG_W-1:0] lookupTag;
  logic             lookupHit;

  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic             updWrite;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  logic [1:0]       ctr_d;

  // Instructions are word aligned, so the low two bits of upd_pc never matter.
  logic unusedLsbs;
  assign unusedLsbs = ^upd_pc[1:0];

  assign lookupIdx        = pc_q[IDX_W+1:2];
  assign lookupTag        = pc_q[31:IDX_W+2];
  assign lookupHit        = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
  assign predict_jump_out = lookupHit && ctr_q[lookupIdx][1];

  assign pc_out    = pc_q;
  assign next_pc   = pc_d;
  assign flush_out = redirect_en;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (!en) begin
      pc_d = pc_q;
    end else if (predict_jump_out) begin
      pc_d = target_q[lookupIdx];
    end
  end

  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[31:IDX_W+2];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

  // A not-taken branch that misses leaves the entry untouched, so no write.
  always_comb begin
    updWrite = 1'b0;
    valid_d  = valid_q[updIdx];
    tag_d    = tag_q[updIdx];
    target_d = target_q[updIdx];
    ctr_d    = ctr_q[updIdx];
    if (upd_en) begin
      if (updHit) begin
        updWrite = 1'b1;
        if (upd_taken) begin
          ctr_d    = (ctr_q[updIdx] == 2'b11) ? 2'b11 : ctr_q[updIdx] + 2'd1;
          target_d = upd_target;
        end else begin
          ctr_d = (ctr_q[updIdx] == 2'b00) ? 2'b00 : ctr_q[updIdx] - 2'd1;
        end
      end else if (upd_taken) begin
        updWrite = 1'b1;
        valid_d  = 1'b1;
        tag_d    = updTag;
        target_d = upd_target;
        ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (updWrite) begin
        valid_q[updIdx]  <= valid_d;
        tag_q[updIdx]    <= tag_d;
        target_q[updIdx] <= target_d;
        ctr_q[updIdx]    <= ctr_d;
      end
    end
  end

endmodule
